ci_issue_queue: RTL and testbench
=================================

CI_ISSUE_QUEUE -- requirements
Module: ci_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the command FIFO entry count (power of two, 2..16).
REQ-002 Parameter OPCODE, default 7'h0B (custom-0), SHALL be the major opcode accepted.
REQ-003 Port UserCLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port UserRST_N  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 Ports ISSUE_VALID in 1, ISSUE_INSTR in 32, ISSUE_OPA in 32, ISSUE_OPB in 32, ISSUE_ID in 4 SHALL carry the CPU issue request.
REQ-006 Ports ISSUE_READY out 1, ISSUE_ACCEPT out 1 SHALL carry the issue response to the CPU.
REQ-007 Ports RESULT_VALID out 1, RESULT_ID out 4, RESULT_RD out 5, RESULT out 32 SHALL carry the writeback to the CPU; there is no backpressure.
REQ-008 Ports ACC_VALID out 1, ACC_READY in 1, ACC_FUNCT3 out 3, ACC_FUNCT7 out 7, ACC_OPA out 32, ACC_OPB out 32 SHALL form the command channel to fabric user logic.
REQ-009 Ports ACC_RES_VALID in 1, ACC_RES in 32 SHALL form the result channel from user logic.

Function
REQ-010 ISSUE_READY SHALL equal (fifo count < DEPTH) and be 0 during reset.
REQ-011 Issue handshake occurs when ISSUE_VALID and ISSUE_READY are both 1.
REQ-012 ISSUE_ACCEPT SHALL be combinational: 1 if the handshake occurs and ISSUE_INSTR[6:0]==OPCODE, else 0.
REQ-013 On an accepted issue, the FIFO SHALL push {ISSUE_ID, INSTR[11:7], INSTR[14:12], INSTR[31:25], OPA, OPB}; a rejected issue SHALL NOT push.
REQ-014 ACC_VALID SHALL be 1 iff state==IDLE and the FIFO is non-empty; ACC_* data SHALL show the FIFO head, zero when empty.
REQ-015 An entry pushed in cycle N SHALL be visible on ACC_VALID no earlier than cycle N+1.
REQ-016 The FSM SHALL have states IDLE and BUSY; IDLE->BUSY on ACC_VALID&&ACC_READY, popping the head and latching its id and rd.
REQ-017 BUSY->IDLE SHALL occur on ACC_RES_VALID; next cycle RESULT_VALID=1 for exactly one cycle with the latched id/rd and ACC_RES.
REQ-018 ACC_RES_VALID in IDLE SHALL be ignored.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and both operations SHALL succeed, including at count==DEPTH (pop only, READY was 0).
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-021 Results SHALL return in issue order; at most one command SHALL be outstanding at user logic.
REQ-022 ACC_VALID, once asserted, SHALL hold with stable data until accepted.

Reset
REQ-023 While UserRST_N=0 at a clock edge: FIFO emptied, pointers/count=0, state=IDLE, latched id/rd=0.
REQ-024 Reset values SHALL be: ISSUE_READY=0, ISSUE_ACCEPT=0, ACC_VALID=0, RESULT_VALID=0, RESULT_ID/RD/RESULT=0, ACC_* data=0.
REQ-025 Reset mid-operation SHALL discard all queued and in-flight commands; no RESULT_VALID SHALL be emitted for them.

Structure
REQ-026 The default opcode, ID width 4, RD width 5 and the FIFO entry field layout SHALL be defined in shared package ci_pkg.
REQ-027 The command storage SHALL be one sub-module, ci_sync_fifo (parameterised width/depth, count-based full/empty).
REQ-028 The block SHALL be registered-output on RESULT_* and shall sit between the CPU-side custom-instruction tile primitive and fabric user logic.

Verification
REQ-029 Issue INSTR=0x0000_B50B, ID=3, OPA=5, OPB=7; user logic READY=1, returns 12 after 2 cycles -> ACCEPT=1, RESULT_VALID pulse with ID=3, RD=10, RESULT=12.
REQ-030 Issue INSTR=0x0000_0033 (opcode 0x33) -> ISSUE_ACCEPT=0, ACC_VALID stays 0, no result.
REQ-031 ACC_READY=0, issue 5 valid instructions back to back at DEPTH=4 -> 4 accepted, ISSUE_READY=0 on the fifth; raise ACC_READY -> results for IDs 0..3 in order.
REQ-032 FIFO full, ACC handshake and ISSUE_VALID in the same cycle -> pop only; next cycle ISSUE_READY=1, count=3.
REQ-033 Assert UserRST_N=0 while BUSY with ID=6 -> after reset all outputs 0, no RESULT_VALID for ID 6 even if ACC_RES_VALID pulses.
REQ-034 ACC_RES_VALID pulsed in IDLE with an empty FIFO -> RESULT_VALID stays 0.

Source files
------------

// File: rtl/ci_pkg.sv
// Shared types for the custom-instruction issue queue: field widths, default
// opcode, the command FIFO entry layout and the sequencer state encoding.
package ci_pkg;

    localparam int ID_W = 4;
    localparam int RD_W = 5;
    localparam logic [6:0] DEFAULT_OPCODE = 7'h0B;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [RD_W-1:0] rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [31:0]     opa;
        logic [31:0]     opb;
    } ci_entry_t;

    localparam int ENTRY_W = $bits(ci_entry_t);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } ci_state_t;

endpackage

// File: rtl/ci_issue_queue_if.sv
// CPU issue/writeback and fabric command/result channels of the issue queue.
interface ci_issue_queue_if;
    import ci_pkg::*;

    logic            ISSUE_VALID;
    logic [31:0]     ISSUE_INSTR;
    logic [31:0]     ISSUE_OPA;
    logic [31:0]     ISSUE_OPB;
    logic [ID_W-1:0] ISSUE_ID;
    logic            ISSUE_READY;
    logic            ISSUE_ACCEPT;

    logic            RESULT_VALID;
    logic [ID_W-1:0] RESULT_ID;
    logic [RD_W-1:0] RESULT_RD;
    logic [31:0]     RESULT;

    logic            ACC_VALID;
    logic            ACC_READY;
    logic [2:0]      ACC_FUNCT3;
    logic [6:0]      ACC_FUNCT7;
    logic [31:0]     ACC_OPA;
    logic [31:0]     ACC_OPB;
    logic            ACC_RES_VALID;
    logic [31:0]     ACC_RES;

    modport slave (
        input  ISSUE_VALID, ISSUE_INSTR, ISSUE_OPA, ISSUE_OPB, ISSUE_ID,
        output ISSUE_READY, ISSUE_ACCEPT,
        output RESULT_VALID, RESULT_ID, RESULT_RD, RESULT,
        output ACC_VALID, ACC_FUNCT3, ACC_FUNCT7, ACC_OPA, ACC_OPB,
        input  ACC_READY, ACC_RES_VALID, ACC_RES
    );

    modport master (
        output ISSUE_VALID, ISSUE_INSTR, ISSUE_OPA, ISSUE_OPB, ISSUE_ID,
        input  ISSUE_READY, ISSUE_ACCEPT,
        input  RESULT_VALID, RESULT_ID, RESULT_RD, RESULT,
        input  ACC_VALID, ACC_FUNCT3, ACC_FUNCT7, ACC_OPA, ACC_OPB,
        output ACC_READY, ACC_RES_VALID, ACC_RES
    );

endinterface

// File: rtl/ci_sync_fifo.sv
// Count-based synchronous FIFO; the head is presented combinationally and
// reads as zero while the FIFO is empty.
module ci_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ci_issue_queue.sv
// Custom-instruction issue queue: buffers accepted CPU issues, hands them one
// at a time to fabric user logic and returns registered, in-order writebacks.
module ci_issue_queue
    import ci_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [6:0] OPCODE = DEFAULT_OPCODE
) (
    input  logic            UserCLK,
    input  logic            UserRST_N,
    ci_issue_queue_if.slave bus
);
    ci_entry_t       push_entry;
    ci_entry_t       head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            issue_ready;
    logic            issue_accept;
    logic            acc_valid;
    logic            acc_fire;

    ci_state_t       state_reg;
    logic [ID_W-1:0] lat_id_reg;
    logic [RD_W-1:0] lat_rd_reg;
    logic            result_valid_reg;
    logic [ID_W-1:0] result_id_reg;
    logic [RD_W-1:0] result_rd_reg;
    logic [31:0]     result_reg;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign issue_ready  = UserRST_N && !fifo_full;
    assign issue_accept = bus.ISSUE_VALID && issue_ready && (bus.ISSUE_INSTR[6:0] == OPCODE);
    assign acc_valid    = (state_reg == ST_IDLE) && !fifo_empty;
    assign acc_fire     = acc_valid && bus.ACC_READY;

    assign push_entry = '{
        id:     bus.ISSUE_ID,
        rd:     bus.ISSUE_INSTR[11:7],
        funct3: bus.ISSUE_INSTR[14:12],
        funct7: bus.ISSUE_INSTR[31:25],
        opa:    bus.ISSUE_OPA,
        opb:    bus.ISSUE_OPB
    };

    ci_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (UserCLK),
        .rst_n (UserRST_N),
        .push  (issue_accept),
        .din   (push_entry),
        .pop   (acc_fire),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge UserCLK) begin
        if (!UserRST_N) begin
            state_reg        <= ST_IDLE;
            lat_id_reg       <= '0;
            lat_rd_reg       <= '0;
            result_valid_reg <= 1'b0;
            result_id_reg    <= '0;
            result_rd_reg    <= '0;
            result_reg       <= '0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (acc_fire) begin
                        state_reg  <= ST_BUSY;
                        lat_id_reg <= head.id;
                        lat_rd_reg <= head.rd;
                    end
                end
                ST_BUSY: begin
                    if (bus.ACC_RES_VALID) begin
                        state_reg        <= ST_IDLE;
                        result_valid_reg <= 1'b1;
                        result_id_reg    <= lat_id_reg;
                        result_rd_reg    <= lat_rd_reg;
                        result_reg       <= bus.ACC_RES;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.ISSUE_READY  = issue_ready;
    assign bus.ISSUE_ACCEPT = issue_accept;
    assign bus.ACC_VALID    = acc_valid;
    assign bus.ACC_FUNCT3   = head.funct3;
    assign bus.ACC_FUNCT7   = head.funct7;
    assign bus.ACC_OPA      = head.opa;
    assign bus.ACC_OPB      = head.opb;
    assign bus.RESULT_VALID = result_valid_reg;
    assign bus.RESULT_ID    = result_id_reg;
    assign bus.RESULT_RD    = result_rd_reg;
    assign bus.RESULT       = result_reg;

endmodule

// File: tb/tb_ci_issue_queue.sv
// Scoreboard bench for ci_issue_queue: a user-logic responder returns OPA+OPB,
// expected writebacks are queued at issue time and popped on RESULT_VALID.
module tb_ci_issue_queue;
    import ci_pkg::*;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ci_issue_queue_if bus();

    ci_issue_queue #(
        .DEPTH  (4),
        .OPCODE (7'h0B)
    ) dut (
        .UserCLK   (clk),
        .UserRST_N (rst_n),
        .bus       (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   resp_delay = 2;
    bit   resp_en = 1'b0;
    int   pulse_req = 0;
    int   pulse_done = 0;

    // User logic model: result = OPA + OPB, returned resp_delay cycles after the handshake.
    initial begin : responder
        logic [31:0] a;
        logic [31:0] b;
        bus.ACC_RES_VALID = 1'b0;
        bus.ACC_RES = 32'h0;
        forever begin
            @(negedge clk);
            if (pulse_req != pulse_done) begin
                @(posedge clk); #1;
                bus.ACC_RES_VALID = 1'b1;
                bus.ACC_RES = 32'hDEAD_BEEF;
                @(posedge clk); #1;
                bus.ACC_RES_VALID = 1'b0;
                pulse_done++;
            end else if (resp_en && bus.ACC_VALID === 1'b1 && bus.ACC_READY === 1'b1) begin
                a = bus.ACC_OPA;
                b = bus.ACC_OPB;
                @(posedge clk);
                repeat (resp_delay - 1) @(posedge clk);
                #1;
                bus.ACC_RES_VALID = 1'b1;
                bus.ACC_RES = a + b;
                @(posedge clk); #1;
                bus.ACC_RES_VALID = 1'b0;
            end
        end
    end

    function automatic logic [31:0] mk_instr(input int id);
        return {7'h00, 10'h000, 3'(id), 5'(id + 1), 7'h0B};
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [3:0] id, input logic [31:0] opa,
                         input logic [31:0] opb, input bit exp_ready, input bit exp_acc);
        @(posedge clk); #1;
        bus.ISSUE_VALID = 1'b1;
        bus.ISSUE_INSTR = instr;
        bus.ISSUE_ID = id;
        bus.ISSUE_OPA = opa;
        bus.ISSUE_OPB = opb;
        @(negedge clk);
        checks++;
        if (bus.ISSUE_READY !== exp_ready) begin
            failures++;
            $display("FAIL issue_ready id=%0d got=%0b exp=%0b", id, bus.ISSUE_READY, exp_ready);
        end
        checks++;
        if (bus.ISSUE_ACCEPT !== exp_acc) begin
            failures++;
            $display("FAIL issue_accept id=%0d got=%0b exp=%0b", id, bus.ISSUE_ACCEPT, exp_acc);
        end
        $display("issue id=%0d instr=%h opa=%0d opb=%0d accept=%0b", id, instr, opa, opb, bus.ISSUE_ACCEPT);
        if (exp_acc) exp_q.push_back('{id: id, rd: instr[11:7], res: opa + opb});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.ISSUE_VALID = 1'b0;
    endtask

    task automatic wait_result(input string name, input int budget);
        exp_t e;
        bit   got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.RESULT_VALID === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s timeout got=no_result exp=result_valid", name);
        end else if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected got id=%0d exp=none", name, bus.RESULT_ID);
        end else begin
            e = exp_q.pop_front();
            if ({bus.RESULT_ID, bus.RESULT_RD, bus.RESULT} !== e) begin
                failures++;
                $display("FAIL %s got id=%0d rd=%0d res=%0d exp id=%0d rd=%0d res=%0d", name,
                         bus.RESULT_ID, bus.RESULT_RD, bus.RESULT, e.id, e.rd, e.res);
            end
            $display("result id=%0d rd=%0d res=%0d", bus.RESULT_ID, bus.RESULT_RD, bus.RESULT);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ISSUE_VALID = 1'b1;
        bus.ISSUE_INSTR = 32'h0000_B50B;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.ISSUE_READY !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", bus.ISSUE_READY); end
        checks++; if (bus.ISSUE_ACCEPT !== 1'b0) begin failures++; $display("FAIL rst_accept got=%0b exp=0", bus.ISSUE_ACCEPT); end
        checks++; if (bus.ACC_VALID !== 1'b0) begin failures++; $display("FAIL rst_acc_valid got=%0b exp=0", bus.ACC_VALID); end
        checks++; if (bus.RESULT_VALID !== 1'b0) begin failures++; $display("FAIL rst_result_valid got=%0b exp=0", bus.RESULT_VALID); end
        checks++;
        if ({bus.RESULT_ID, bus.RESULT_RD, bus.RESULT} !== 41'h0) begin
            failures++;
            $display("FAIL rst_result_data got=%h exp=0", {bus.RESULT_ID, bus.RESULT_RD, bus.RESULT});
        end
        checks++;
        if ({bus.ACC_FUNCT3, bus.ACC_FUNCT7, bus.ACC_OPA, bus.ACC_OPB} !== 74'h0) begin
            failures++;
            $display("FAIL rst_acc_data got=%h exp=0", {bus.ACC_FUNCT3, bus.ACC_FUNCT7, bus.ACC_OPA, bus.ACC_OPB});
        end
        bus.ISSUE_VALID = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.ISSUE_READY !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%0b exp=1", bus.ISSUE_READY); end
    endtask

    task automatic test_basic();
        resp_en = 1'b1;
        resp_delay = 2;
        bus.ACC_READY = 1'b1;
        issue(32'h0000_B50B, 4'd3, 32'd5, 32'd7, 1'b1, 1'b1);
        checks++; if (bus.ACC_VALID !== 1'b0) begin failures++; $display("FAIL basic_early_acc_valid got=%0b exp=0", bus.ACC_VALID); end
        idle();
        @(negedge clk);
        checks++; if (bus.ACC_VALID !== 1'b1) begin failures++; $display("FAIL basic_acc_valid got=%0b exp=1", bus.ACC_VALID); end
        checks++;
        if ({bus.ACC_FUNCT3, bus.ACC_FUNCT7, bus.ACC_OPA, bus.ACC_OPB} !== {3'd3, 7'd0, 32'd5, 32'd7}) begin
            failures++;
            $display("FAIL basic_acc_data got f3=%0d f7=%0d a=%0d b=%0d exp f3=3 f7=0 a=5 b=7",
                     bus.ACC_FUNCT3, bus.ACC_FUNCT7, bus.ACC_OPA, bus.ACC_OPB);
        end
        wait_result("basic_result", 20);
        @(negedge clk);
        checks++; if (bus.RESULT_VALID !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%0b exp=0", bus.RESULT_VALID); end
    endtask

    task automatic test_reject();
        bit seen_acc = 1'b0;
        bit seen_res = 1'b0;
        issue(32'h0000_0033, 4'd1, 32'd1, 32'd2, 1'b1, 1'b0);
        idle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.ACC_VALID !== 1'b0) seen_acc = 1'b1;
            if (bus.RESULT_VALID !== 1'b0) seen_res = 1'b1;
        end
        checks++; if (seen_acc) begin failures++; $display("FAIL reject_acc_valid got=1 exp=0"); end
        checks++; if (seen_res) begin failures++; $display("FAIL reject_result got=1 exp=0"); end
    endtask

    task automatic test_fill();
        bit moved = 1'b0;
        bus.ACC_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(mk_instr(i), 4'(i), 32'h100 + 32'(i * 16), 32'(100 + i), i < 4, i < 4);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.ACC_VALID !== 1'b1 || bus.ACC_OPA !== 32'h100) moved = 1'b1;
        end
        checks++; if (moved) begin failures++; $display("FAIL fill_hold got opa=%h valid=%0b exp opa=100 valid=1", bus.ACC_OPA, bus.ACC_VALID); end
        @(posedge clk); #1;
        bus.ACC_READY = 1'b1;
        for (int i = 0; i < 4; i++) wait_result("fill_result", 30);
    endtask

    task automatic test_full_pop();
        bus.ACC_READY = 1'b0;
        for (int i = 8; i < 12; i++) begin
            issue(mk_instr(i), 4'(i), 32'(i), 32'h1000, 1'b1, 1'b1);
        end
        @(posedge clk); #1;
        bus.ISSUE_VALID = 1'b1;
        bus.ISSUE_INSTR = mk_instr(12);
        bus.ISSUE_ID = 4'd12;
        bus.ACC_READY = 1'b1;
        @(negedge clk);
        checks++; if (bus.ISSUE_READY !== 1'b0) begin failures++; $display("FAIL fullpop_ready got=%0b exp=0", bus.ISSUE_READY); end
        checks++; if (bus.ISSUE_ACCEPT !== 1'b0) begin failures++; $display("FAIL fullpop_accept got=%0b exp=0", bus.ISSUE_ACCEPT); end
        checks++; if (bus.ACC_VALID !== 1'b1 || bus.ACC_OPA !== 32'd8) begin failures++; $display("FAIL fullpop_head got valid=%0b opa=%0d exp valid=1 opa=8", bus.ACC_VALID, bus.ACC_OPA); end
        @(posedge clk); #1;
        bus.ISSUE_VALID = 1'b0;
        bus.ACC_READY = 1'b0;
        @(negedge clk);
        checks++; if (bus.ISSUE_READY !== 1'b1) begin failures++; $display("FAIL fullpop_ready_after got=%0b exp=1", bus.ISSUE_READY); end
        checks++; if (bus.ACC_VALID !== 1'b0) begin failures++; $display("FAIL fullpop_busy got=%0b exp=0", bus.ACC_VALID); end
        wait_result("fullpop_result", 20);
        issue(mk_instr(12), 4'd12, 32'd12, 32'h1000, 1'b1, 1'b1);
        issue(mk_instr(13), 4'd13, 32'd13, 32'h1000, 1'b0, 1'b0);
        idle();
        bus.ACC_READY = 1'b1;
        for (int i = 0; i < 4; i++) wait_result("fullpop_drain", 30);
    endtask

    task automatic test_reset_busy();
        bit seen = 1'b0;
        bit seen_res = 1'b0;
        resp_delay = 6;
        bus.ACC_READY = 1'b1;
        issue(mk_instr(6), 4'd6, 32'd60, 32'd6, 1'b1, 1'b1);
        idle();
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.ACC_VALID === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL rstbusy_handshake got=no_acc_valid exp=acc_valid"); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ACC_VALID, bus.ISSUE_ACCEPT, bus.RESULT_VALID, bus.RESULT_ID, bus.RESULT_RD, bus.RESULT} !== 44'h0) begin
            failures++;
            $display("FAIL rstbusy_outputs got acc_v=%0b res_v=%0b id=%0d rd=%0d res=%0d exp all 0",
                     bus.ACC_VALID, bus.RESULT_VALID, bus.RESULT_ID, bus.RESULT_RD, bus.RESULT);
        end
        checks++;
        if ({bus.ACC_FUNCT3, bus.ACC_FUNCT7, bus.ACC_OPA, bus.ACC_OPB} !== 74'h0) begin
            failures++;
            $display("FAIL rstbusy_acc_data got=%h exp=0", {bus.ACC_FUNCT3, bus.ACC_FUNCT7, bus.ACC_OPA, bus.ACC_OPB});
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.RESULT_VALID !== 1'b0) seen_res = 1'b1;
        end
        checks++; if (seen_res) begin failures++; $display("FAIL rstbusy_result got id=%0d exp=none", bus.RESULT_ID); end
        resp_delay = 2;
    endtask

    task automatic test_idle_res();
        bit seen_res = 1'b0;
        pulse_req++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.RESULT_VALID !== 1'b0) seen_res = 1'b1;
        end
        checks++; if (seen_res) begin failures++; $display("FAIL idle_res_result got=1 exp=0"); end
        checks++; if (bus.ACC_VALID !== 1'b0) begin failures++; $display("FAIL idle_res_acc_valid got=%0b exp=0", bus.ACC_VALID); end
    endtask

    initial begin
        bus.ISSUE_VALID = 1'b0;
        bus.ISSUE_INSTR = 32'h0;
        bus.ISSUE_OPA = 32'h0;
        bus.ISSUE_OPB = 32'h0;
        bus.ISSUE_ID = 4'h0;
        bus.ACC_READY = 1'b0;
        test_reset();
        test_basic();
        test_reject();
        test_fill();
        test_full_pop();
        test_reset_busy();
        test_idle_res();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
